syn_current_accum: RTL and testbench

Downstream consumer of the STDP learning stage. It holds a local copy of the synaptic weight table, kept in step through the STDP write port (WE/ADDR/WEIGHT). On each START it computes the total synaptic input current I_SYN = sum of weight[i] over every input i whose pre-spike bit is set. I_SYN drives the Izhikevich neuron core's current input, and weights are IEEE-754 single precision throughout.

---
 rtl/syn_current_accum.sv | 169 ++++++++++++++++
 tb/tb_syn_current_accum.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/syn_current_accum.sv
// Synaptic current accumulator: a local fp32 weight table kept in step by the STDP
// write port, plus a one-synapse-per-cycle pass that sums the weights of spiking inputs.

module syn_fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        swap, sl, sub, rnd;
  logic [31:0] xl, xs;
  logic [9:0]  el, es, d, e, e_out, lz, sh;
  logic [26:0] ml_x, ms_x, ms_sh, norm;
  logic [27:0] sum;
  logic [24:0] mant;
  logic [22:0] frac;
  logic [4:0]  pos;

  always_comb begin
    pos   = '0;
    lz    = '0;
    sh    = '0;
    // Order operands by magnitude so the subtract never goes negative
    swap  = (b[30:0] > a[30:0]);
    xl    = swap ? b : a;
    xs    = swap ? a : b;
    sl    = xl[31];
    sub   = xl[31] ^ xs[31];
    el    = {2'b0, (xl[30:23] == 8'd0) ? 8'd1 : xl[30:23]};
    es    = {2'b0, (xs[30:23] == 8'd0) ? 8'd1 : xs[30:23]};
    ml_x  = {(xl[30:23] != 8'd0), xl[22:0], 3'b000};
    ms_x  = {(xs[30:23] != 8'd0), xs[22:0], 3'b000};
    d     = el - es;
    if (d >= 10'd27) begin
      ms_sh = {26'b0, |ms_x};
    end else begin
      ms_sh    = ms_x >> d;
      ms_sh[0] = ms_sh[0] | (|(ms_x & ~(27'h7FFFFFF << d)));
    end
    sum = sub ? ({1'b0, ml_x} - {1'b0, ms_sh}) : ({1'b0, ml_x} + {1'b0, ms_sh});
    for (int i = 0; i < 27; i++)
      if (sum[i]) pos = 5'(i);
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = el + 10'd1;
    end else begin
      // Left-normalise, but stop at the minimum exponent so tiny results go subnormal
      lz   = 10'd26 - {5'b0, pos};
      sh   = (lz < el) ? lz : (el - 10'd1);
      norm = sum[26:0] << sh;
      e    = el - sh;
    end
    rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant = {1'b0, norm[26:3]} + {24'b0, rnd};
    if (mant[24]) begin
      e_out = e + 10'd1;
      frac  = mant[23:1];
    end else begin
      e_out = mant[23] ? e : 10'd0;
      frac  = mant[22:0];
    end
    y = {sl, e_out[7:0], frac};
    if (e_out >= 10'd255) y = {sl, 8'hFF, 23'b0};
    if (sum == 28'd0) y = {a[31] & b[31], 31'b0};
    if (xl[30:23] == 8'hFF) begin
      if (xl[22:0] != 23'd0 || (xs[30:23] == 8'hFF && sub)) y = 32'h7FC00000;
      else y = xl;
    end
  end
endmodule

module syn_current_accum #(
  parameter int NUM_SYN = 10,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WE,
  input  logic [ADDR_W-1:0]  ADDR,
  input  logic [DATA_W-1:0]  WEIGHT,
  input  logic               START,
  input  logic [NUM_SYN-1:0] PRE_SPIKES,
  output logic               BUSY,
  output logic               DONE,
  output logic [DATA_W-1:0]  I_SYN
);
  localparam int IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SYN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t                           state, state_nxt;
  wr_req_t                          wr;
  logic [NUM_SYN-1:0][DATA_W-1:0]   w_q;
  logic [NUM_SYN-1:0]               spike_q;
  logic [IDX_W-1:0]                 idx;
  logic [DATA_W-1:0]                acc, acc_sum;

  assign wr = '{we: WE, addr: ADDR, data: WEIGHT};

  // Out-of-range addresses match no entry and are dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SYN; i++)
        if (wr.we && wr.addr == ADDR_W'(i)) w_q[i] <= wr.data;
    end
  end

  // Reads the pre-edge entry, so a same-cycle write only lands for the next pass
  syn_fp32_add u_add (
    .a (acc),
    .b (w_q[idx]),
    .y (acc_sum)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      spike_q <= '0;
      idx     <= '0;
      acc     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      I_SYN   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          spike_q <= PRE_SPIKES;
          acc     <= '0;
          idx     <= '0;
          BUSY    <= 1'b1;
        end
        ACCUM: begin
          if (spike_q[idx]) acc <= acc_sum;
          if (idx != LAST) idx <= idx + IDX_W'(1);
        end
        FINISH: begin
          I_SYN <= acc;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_syn_current_accum.sv
// Directed bench for syn_current_accum: latency, sums, write collision, ignored
// inputs, back-to-back throughput and mid-pass reset.

module tb_syn_current_accum;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE = 1'b0;
  logic [8:0]  ADDR = '0;
  logic [31:0] WEIGHT = '0;
  logic        START = 1'b0;
  logic [9:0]  PRE_SPIKES = '0;
  logic        BUSY, DONE;
  logic [31:0] I_SYN;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  syn_current_accum dut (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .WEIGHT(WEIGHT),
    .START(START), .PRE_SPIKES(PRE_SPIKES), .BUSY(BUSY), .DONE(DONE), .I_SYN(I_SYN)
  );

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic write_w(input logic [8:0] a, input logic [31:0] d);
    WE = 1'b1; ADDR = a; WEIGHT = d;
    step();
    WE = 1'b0;
  endtask

  // Launch one pass, scramble PRE_SPIKES after the latch, wait (bounded) for DONE
  task automatic run_pass(input logic [9:0] sp, output logic [31:0] res,
                          output int lat, output int busy_n);
    START = 1'b1; PRE_SPIKES = sp;
    step();
    START = 1'b0; PRE_SPIKES = ~sp;
    lat = 0;
    busy_n = BUSY ? 1 : 0;
    while (!DONE && lat < 40) begin
      step();
      lat++;
      if (BUSY) busy_n++;
    end
    res = I_SYN;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (I_SYN !== 32'h0) begin errors++; $display("FAIL reset_isyn: got %h expected 00000000", I_SYN); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_all_zero();
    logic [31:0] r; int lat, bn;
    run_pass(10'h3FF, r, lat, bn);
    checks++; if (lat !== 11) begin errors++; $display("FAIL zero_latency: got %0d expected 11", lat); end
    checks++; if (bn !== 11) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 11", bn); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL zero_isyn: got %h expected 00000000", r); end
    step();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", DONE); end
  endtask

  task automatic test_sums();
    logic [31:0] r; int lat, bn;
    write_w(9'd0, 32'h3F800000);
    write_w(9'd1, 32'h40000000);
    write_w(9'd2, 32'hBF800000);
    run_pass(10'h007, r, lat, bn);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL sum_007: got %h expected 40000000", r); end
    run_pass(10'h003, r, lat, bn);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL sum_003: got %h expected 40400000", r); end
    run_pass(10'h004, r, lat, bn);
    checks++; if (r !== 32'hBF800000) begin errors++; $display("FAIL sum_004: got %h expected bf800000", r); end
  endtask

  task automatic test_collision();
    logic [31:0] r; int lat, bn;
    START = 1'b1; PRE_SPIKES = 10'h002;
    step();
    START = 1'b0;
    step();
    WE = 1'b1; ADDR = 9'd1; WEIGHT = 32'h3F000000;
    step();
    WE = 1'b0;
    lat = 0;
    while (!DONE && lat < 40) begin step(); lat++; end
    checks++; if (I_SYN !== 32'h40000000) begin errors++; $display("FAIL collide_same_pass: got %h expected 40000000", I_SYN); end
    run_pass(10'h002, r, lat, bn);
    checks++; if (r !== 32'h3F000000) begin errors++; $display("FAIL collide_next_pass: got %h expected 3f000000", r); end
  endtask

  task automatic test_ignored();
    logic [31:0] r; int lat, bn, n_done;
    START = 1'b1; PRE_SPIKES = 10'h3FF;
    step();
    START = 1'b0;
    step(); step();
    WE = 1'b1; ADDR = 9'd10; WEIGHT = 32'h40800000; START = 1'b1;
    step();
    ADDR = 9'd16;
    step();
    WE = 1'b0; START = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (DONE) n_done++;
      step();
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
    checks++; if (I_SYN !== 32'h3F000000) begin errors++; $display("FAIL ignore_isyn: got %h expected 3f000000", I_SYN); end
    run_pass(10'h3FF, r, lat, bn);
    checks++; if (r !== 32'h3F000000) begin errors++; $display("FAIL ignore_table: got %h expected 3f000000", r); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    START = 1'b1; PRE_SPIKES = 10'h001;
    step();
    n1 = 0;
    while (!DONE && n1 < 40) begin step(); n1++; end
    n2 = 0;
    do begin step(); n2++; end while (!DONE && n2 < 40);
    START = 1'b0;
    checks++; if (n1 !== 11) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 11", n1); end
    checks++; if (n2 !== 12) begin errors++; $display("FAIL b2b_period: got %0d expected 12", n2); end
    checks++; if (I_SYN !== 32'h3F800000) begin errors++; $display("FAIL b2b_isyn: got %h expected 3f800000", I_SYN); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, bn, n_done;
    START = 1'b1; PRE_SPIKES = 10'h3FF;
    step();
    START = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", DONE); end
    checks++; if (I_SYN !== 32'h0) begin errors++; $display("FAIL midrst_isyn: got %h expected 00000000", I_SYN); end
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (DONE) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_stray_done: got %0d expected 0", n_done); end
    run_pass(10'h3FF, r, lat, bn);
    checks++; if (lat !== 11) begin errors++; $display("FAIL midrst_latency: got %0d expected 11", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midrst_fresh_isyn: got %h expected 00000000", r); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_sums();
    test_collision();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
